// File: rtl/bopit_tempo_ctrl_if.sv
// Handshake bundle between the Bop-it round sequencer and its neighbours:
// the input/debounce side drives start and actions; the sequencer reports
// prompts, slow ticks, tempo and score back.
interface bopit_tempo_ctrl_if #(
    parameter int DIV_W   = 32,
    parameter int SCORE_W = 8
);
    logic               start;
    logic               action_valid;
    logic               action_match;
    logic               cmd_req;
    logic               tick;
    logic [3:0]         ticks_left;
    logic [DIV_W-1:0]   cur_period;
    logic [SCORE_W-1:0] score;
    logic               busy;
    logic               game_over;

    modport master (
        output start, action_valid, action_match,
        input  cmd_req, tick, ticks_left, cur_period, score, busy, game_over
    );

    modport slave (
        input  start, action_valid, action_match,
        output cmd_req, tick, ticks_left, cur_period, score, busy, game_over
    );
endinterface

// File: rtl/bopit_tempo_ctrl.sv
// Bop-it round sequencer: requests a prompt, times the response window with a
// programmable slow-tick divider, scores hits and speeds the tempo up each
// round until the player misses or runs out of time.
module bopit_tempo_ctrl #(
    parameter int DIV_W        = 32,
    parameter int START_DIV    = 25000000,
    parameter int MIN_DIV      = 6250000,
    parameter int STEP_DIV     = 1250000,
    parameter int WINDOW_TICKS = 4,
    parameter int SCORE_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    bopit_tempo_ctrl_if.slave   ctrl_io
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PROMPT = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_HIT    = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    localparam logic [DIV_W-1:0] START_P = DIV_W'(START_DIV);
    localparam logic [DIV_W-1:0] MIN_P   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] STEP_P  = DIV_W'(STEP_DIV);
    localparam logic [3:0]       WIN_T   = 4'(WINDOW_TICKS);

    logic [2:0]         state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         ticks_q, ticks_d;
    logic               tick_q, tick_d;
    logic               cmd_req_q, busy_q, game_over_q;
    logic [DIV_W:0]     diff;

    // Round sequencing: start/restart, window accounting, scoring and tempo step.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        score_d  = score_q;
        ticks_d  = ticks_q;
        diff     = {1'b0, period_q} - {1'b0, STEP_P};
        case (state_q)
            S_IDLE, S_OVER: begin
                if (ctrl_io.start) begin
                    state_d  = S_PROMPT;
                    score_d  = '0;
                    period_d = START_P;
                end
            end
            S_PROMPT: begin
                ticks_d = WIN_T;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ctrl_io.action_valid && ctrl_io.action_match) begin
                    state_d = S_HIT;
                end else if (ctrl_io.action_valid) begin
                    state_d = S_OVER;
                end else if (tick_q) begin
                    if (ticks_q == 4'd1) begin
                        ticks_d = 4'd0;
                        state_d = S_OVER;
                    end else begin
                        ticks_d = ticks_q - 4'd1;
                    end
                end
            end
            S_HIT: begin
                score_d  = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                period_d = (diff[DIV_W] || (diff[DIV_W-1:0] < MIN_P)) ? MIN_P : diff[DIV_W-1:0];
                state_d  = S_PROMPT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slow-tick divider, only counting while the window stays open.
    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (state_q == S_WAIT && state_d == S_WAIT) begin
            if (cnt_q == period_q - DIV_W'(1)) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // State and registered outputs; flags follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            period_q    <= START_P;
            score_q     <= '0;
            ticks_q     <= 4'd0;
            tick_q      <= 1'b0;
            cmd_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            score_q     <= score_d;
            ticks_q     <= ticks_d;
            tick_q      <= tick_d;
            cmd_req_q   <= (state_d == S_PROMPT);
            busy_q      <= (state_d == S_PROMPT) || (state_d == S_WAIT) || (state_d == S_HIT);
            game_over_q <= (state_d == S_OVER);
        end
    end

    assign ctrl_io.cmd_req    = cmd_req_q;
    assign ctrl_io.tick       = tick_q;
    assign ctrl_io.ticks_left = ticks_q;
    assign ctrl_io.cur_period = period_q;
    assign ctrl_io.score      = score_q;
    assign ctrl_io.busy       = busy_q;
    assign ctrl_io.game_over  = game_over_q;

endmodule

// File: tb/tb_bopit_tempo_ctrl.sv
// Directed bench for the Bop-it round sequencer using a short tempo
// (start 10, floor 4, step 3, window of 3 ticks).
module tb_bopit_tempo_ctrl;

    localparam int DIV_W   = 8;
    localparam int SCORE_W = 8;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   n;
    int   tickCount;
    int   expPeriod [4];

    bopit_tempo_ctrl_if #(.DIV_W(DIV_W), .SCORE_W(SCORE_W)) bus ();

    bopit_tempo_ctrl #(
        .DIV_W(DIV_W), .START_DIV(10), .MIN_DIV(4), .STEP_DIV(3),
        .WINDOW_TICKS(3), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctrl_io(bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic av, input logic am);
        bus.start        = st;
        bus.action_valid = av;
        bus.action_match = am;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.action_valid = 1'b0;
        bus.action_match = 1'b0;
    endtask

    task automatic waitTick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.tick !== 1'b1 && cycles < 200);
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        expPeriod        = '{7, 4, 4, 4};
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.action_valid = 1'b0;
        bus.action_match = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_cmd_req", bus.cmd_req, 0);
        checkOutput("rst_tick", bus.tick, 0);
        checkOutput("rst_ticks_left", bus.ticks_left, 0);
        checkOutput("rst_cur_period", bus.cur_period, 10);
        checkOutput("rst_score", bus.score, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_game_over", bus.game_over, 0);
        tickCount = 0;
        repeat (50) begin
            @(negedge clk);
            tickCount += int'(bus.tick);
        end
        checkOutput("idle_no_tick", tickCount, 0);

        // Timeout after three ticks
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("to_cmd_req_on", bus.cmd_req, 1);
        checkOutput("to_busy", bus.busy, 1);
        @(negedge clk);
        checkOutput("to_cmd_req_off", bus.cmd_req, 0);
        checkOutput("to_ticks_left3", bus.ticks_left, 3);
        waitTick(n);
        checkOutput("to_first_tick_gap", n, 10);
        checkOutput("to_tl_at_tick1", bus.ticks_left, 3);
        waitTick(n);
        checkOutput("to_tick_gap2", n, 10);
        checkOutput("to_tl_at_tick2", bus.ticks_left, 2);
        waitTick(n);
        checkOutput("to_tick_gap3", n, 10);
        checkOutput("to_tl_at_tick3", bus.ticks_left, 1);
        @(negedge clk);
        checkOutput("to_ticks_left0", bus.ticks_left, 0);
        checkOutput("to_game_over", bus.game_over, 1);
        checkOutput("to_busy_off", bus.busy, 0);
        checkOutput("to_score", bus.score, 0);
        checkOutput("to_tick_off", bus.tick, 0);

        // Tempo shrink over four hits
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ts_cmd_req", bus.cmd_req, 1);
        checkOutput("ts_period_start", bus.cur_period, 10);
        checkOutput("ts_game_over_off", bus.game_over, 0);
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            repeat (2) @(negedge clk);
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("ts_hit_busy", bus.busy, 1);
            checkOutput("ts_hit_no_cmd", bus.cmd_req, 0);
            @(negedge clk);
            checkOutput("ts_cmd_req", bus.cmd_req, 1);
            checkOutput("ts_score", bus.score, r + 1);
            checkOutput("ts_period", bus.cur_period, expPeriod[r]);
            @(negedge clk);
        end

        // Wrong action ends the game; later actions ignored
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("wa_game_over", bus.game_over, 1);
        checkOutput("wa_busy", bus.busy, 0);
        checkOutput("wa_score", bus.score, 4);
        checkOutput("wa_period", bus.cur_period, 4);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("wa_ign_game_over", bus.game_over, 1);
        checkOutput("wa_ign_score", bus.score, 4);
        checkOutput("wa_ign_cmd_req", bus.cmd_req, 0);

        // Matching action on the final tick wins
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        waitTick(n);
        waitTick(n);
        waitTick(n);
        checkOutput("race_final_tl", bus.ticks_left, 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("race_hit_busy", bus.busy, 1);
        checkOutput("race_hit_no_over", bus.game_over, 0);
        checkOutput("race_hit_tl", bus.ticks_left, 1);
        @(negedge clk);
        checkOutput("race_hit_score", bus.score, 1);
        checkOutput("race_hit_cmd", bus.cmd_req, 1);
        checkOutput("race_hit_period", bus.cur_period, 7);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("race_score2", bus.score, 2);
        checkOutput("race_period4", bus.cur_period, 4);
        @(negedge clk);
        // Wrong action on the final tick
        waitTick(n);
        waitTick(n);
        waitTick(n);
        checkOutput("race_gap4", n, 4);
        checkOutput("race_wrong_tl", bus.ticks_left, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("race_wrong_over", bus.game_over, 1);
        checkOutput("race_wrong_tl_held", bus.ticks_left, 1);
        checkOutput("race_wrong_score", bus.score, 2);

        // Restart from OVER, then reset mid-window
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rs_score", bus.score, 0);
        checkOutput("rs_period", bus.cur_period, 10);
        checkOutput("rs_cmd_req", bus.cmd_req, 1);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("rs_score1", bus.score, 1);
        @(negedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mr_busy", bus.busy, 0);
        checkOutput("mr_game_over", bus.game_over, 0);
        checkOutput("mr_score", bus.score, 0);
        checkOutput("mr_period", bus.cur_period, 10);
        checkOutput("mr_ticks_left", bus.ticks_left, 0);
        checkOutput("mr_cmd_req", bus.cmd_req, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        waitTick(n);
        checkOutput("mr_first_tick_gap", n, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
